// File: rtl/ccd_acq_sequencer_pkg.sv
// Shared types and default constants for the CCD acquisition sequencer.
package ccd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_ARM          = 3'd1,
    ST_WAIT_SH_FALL = 3'd2,
    ST_FLUSH        = 3'd3,
    ST_SKIP         = 3'd4,
    ST_CAPTURE      = 3'd5
  } state_e;

  localparam int C_PIXELS     = 5340;
  localparam int C_DUMMY_LEAD = 64;
  localparam int C_TRIG_W     = 4;
  localparam int C_ADC_W      = 12;
  localparam int C_SAMPLE_DLY = 6;
  localparam int C_TIMEOUT    = 2000000;

endpackage

// File: rtl/ccd_acq_sequencer_if.sv
// Pixel stream towards the line-buffer writer: one-entry valid/ready with line markers.
interface ccd_acq_sequencer_if #(
  parameter int ADC_W = 12
) ();
  logic [ADC_W-1:0] pix_data;
  logic             pix_valid;
  logic             pix_ready;
  logic             pix_sol;
  logic             pix_eol;

  modport master (output pix_data, pix_valid, pix_sol, pix_eol, input pix_ready);
  modport slave  (input pix_data, pix_valid, pix_sol, pix_eol, output pix_ready);
endinterface

// File: rtl/ccd_sync_edge.sv
// Two-flop synchronizer plus registered rise/fall pulses; pulses lag the pin by 3 cycles.
module ccd_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);
  logic [2:0] sync_q, sync_d;
  logic       rise_q, rise_d;
  logic       fall_q, fall_d;

  always_comb begin
    sync_d = {sync_q[1:0], din};
    rise_d = sync_q[1] & ~sync_q[2];
    fall_d = ~sync_q[1] & sync_q[2];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;
endmodule

// File: rtl/ccd_acq_sequencer.sv
// Arms the TCD1500C timing generator, follows SH/SP to frame lines and streams effective pixels.
//   state        | meaning
//   IDLE         | waiting for start
//   ARM          | TRIG pulse, then wait for first SH rise
//   WAIT_SH_FALL | line boundary, wait for SH fall
//   FLUSH        | discarded line, wait for SH rise
//   SKIP         | counting leading dummy SP pulses
//   CAPTURE      | sampling ADC on each SP pulse
module ccd_acq_sequencer
  import ccd_pkg::*;
#(
  parameter int PIXELS     = C_PIXELS,
  parameter int DUMMY_LEAD = C_DUMMY_LEAD,
  parameter int ADC_W      = C_ADC_W,
  parameter int SAMPLE_DLY = C_SAMPLE_DLY,
  parameter int TIMEOUT    = C_TIMEOUT
) (
  input  logic                CLK20M,
  input  logic                RST,
  input  logic                start,
  input  logic                abort,
  input  logic [7:0]          cfg_lines,
  input  logic [3:0]          cfg_flush,
  output logic                trig,
  input  logic                ccd_sh,
  input  logic                ccd_sp,
  input  logic [ADC_W-1:0]    adc_data,
  ccd_acq_sequencer_if.master pix,
  output logic                busy,
  output logic                done,
  output logic                overrun,
  output logic                err_timeout
);
  localparam logic [12:0] PIX_LAST  = 13'(PIXELS - 1);
  localparam logic [6:0]  SKIP_LOAD = 7'(DUMMY_LEAD - 1);
  localparam logic [3:0]  DLY_LOAD  = 4'(SAMPLE_DLY);
  localparam logic [20:0] TO_LOAD   = 21'(TIMEOUT - 1);
  localparam logic [2:0]  TRIG_LAST = 3'(C_TRIG_W);

  state_e           state_q, state_d;
  logic [2:0]       trig_cnt_q, trig_cnt_d;
  logic [7:0]       lines_cfg_q, lines_cfg_d;
  logic [3:0]       flush_cnt_q, flush_cnt_d;
  logic [7:0]       line_cnt_q, line_cnt_d;
  logic [6:0]       skip_cnt_q, skip_cnt_d;
  logic [12:0]      pix_idx_q, pix_idx_d;
  logic [3:0]       dly_cnt_q, dly_cnt_d;
  logic             dly_act_q, dly_act_d;
  logic [20:0]      to_cnt_q, to_cnt_d;
  logic             pix_valid_q, pix_valid_d;
  logic [ADC_W-1:0] pix_data_q, pix_data_d;
  logic             pix_sol_q, pix_sol_d;
  logic             pix_eol_q, pix_eol_d;
  logic             done_q, done_d;
  logic             overrun_q, overrun_d;
  logic             err_q, err_d;
  logic             sample;
  logic             sh_rise, sh_fall, sp_rise, sp_fall_unused;

  ccd_sync_edge u_sync_sh (.clk(CLK20M), .rst(RST), .din(ccd_sh), .rise(sh_rise), .fall(sh_fall));
  ccd_sync_edge u_sync_sp (.clk(CLK20M), .rst(RST), .din(ccd_sp), .rise(sp_rise), .fall(sp_fall_unused));

  always_comb begin
    state_d     = state_q;
    trig_cnt_d  = trig_cnt_q;
    lines_cfg_d = lines_cfg_q;
    flush_cnt_d = flush_cnt_q;
    line_cnt_d  = line_cnt_q;
    skip_cnt_d  = skip_cnt_q;
    pix_idx_d   = pix_idx_q;
    dly_cnt_d   = dly_cnt_q;
    dly_act_d   = dly_act_q;
    to_cnt_d    = to_cnt_q;
    pix_valid_d = pix_valid_q;
    pix_data_d  = pix_data_q;
    pix_sol_d   = pix_sol_q;
    pix_eol_d   = pix_eol_q;
    done_d      = 1'b0;
    overrun_d   = overrun_q;
    err_d       = err_q;
    sample      = 1'b0;

    if (pix_valid_q && pix.pix_ready) pix_valid_d = 1'b0;

    if (dly_act_q) begin
      if (dly_cnt_q == '0) dly_act_d = 1'b0;
      else dly_cnt_d = dly_cnt_q - 4'd1;
    end

    if (state_q != ST_IDLE) begin
      if (sh_rise || sh_fall) to_cnt_d = TO_LOAD;
      else if (to_cnt_q != '0) to_cnt_d = to_cnt_q - 21'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d     = ST_ARM;
          lines_cfg_d = cfg_lines;
          flush_cnt_d = cfg_flush;
          line_cnt_d  = '0;
          trig_cnt_d  = '0;
          pix_idx_d   = '0;
          to_cnt_d    = TO_LOAD;
          overrun_d   = 1'b0;
          err_d       = 1'b0;
        end
      end
      ST_ARM: begin
        if (trig_cnt_q != TRIG_LAST) trig_cnt_d = trig_cnt_q + 3'd1;
        else if (sh_rise) state_d = ST_WAIT_SH_FALL;
      end
      ST_WAIT_SH_FALL: begin
        if (sh_fall) begin
          if (flush_cnt_q != '0) begin
            state_d = ST_FLUSH;
          end else begin
            state_d    = ST_SKIP;
            skip_cnt_d = SKIP_LOAD;
          end
        end
      end
      ST_FLUSH: begin
        if (sh_rise) begin
          flush_cnt_d = flush_cnt_q - 4'd1;
          state_d     = ST_WAIT_SH_FALL;
        end
      end
      ST_SKIP: begin
        if (sh_rise) begin
          overrun_d = 1'b1;
          state_d   = ST_WAIT_SH_FALL;
        end else if (sp_rise) begin
          if (skip_cnt_q == '0) begin
            state_d   = ST_CAPTURE;
            pix_idx_d = '0;
          end else begin
            skip_cnt_d = skip_cnt_q - 7'd1;
          end
        end
      end
      ST_CAPTURE: begin
        // An SH rise here means the line was cut short: flag it, never count it.
        if (sh_rise) begin
          overrun_d = 1'b1;
          state_d   = ST_WAIT_SH_FALL;
        end else begin
          if (sp_rise) begin
            dly_cnt_d = DLY_LOAD;
            dly_act_d = 1'b1;
          end
          if (dly_act_q && dly_cnt_q == '0) begin
            sample    = 1'b1;
            pix_idx_d = pix_idx_q + 13'd1;
            if (pix_idx_q == PIX_LAST) begin
              pix_idx_d  = '0;
              line_cnt_d = line_cnt_q + 8'd1;
              if (lines_cfg_q != '0 && line_cnt_d == lines_cfg_q) begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
              end else begin
                state_d = ST_WAIT_SH_FALL;
              end
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (sample) begin
      if (pix_valid_q && !pix.pix_ready) begin
        overrun_d = 1'b1;
      end else begin
        pix_valid_d = 1'b1;
        pix_data_d  = adc_data;
        pix_sol_d   = (pix_idx_q == '0);
        pix_eol_d   = (pix_idx_q == PIX_LAST);
      end
    end

    if (state_q != ST_IDLE && !sh_rise && !sh_fall && to_cnt_q == '0) begin
      err_d   = 1'b1;
      state_d = ST_IDLE;
      done_d  = 1'b0;
    end

    if (abort) begin
      state_d = ST_IDLE;
      done_d  = 1'b0;
    end

    if (state_d != ST_CAPTURE) dly_act_d = 1'b0;
  end

  always_ff @(posedge CLK20M or posedge RST) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      trig_cnt_q  <= '0;
      lines_cfg_q <= '0;
      flush_cnt_q <= '0;
      line_cnt_q  <= '0;
      skip_cnt_q  <= '0;
      pix_idx_q   <= '0;
      dly_cnt_q   <= '0;
      dly_act_q   <= 1'b0;
      to_cnt_q    <= '0;
      pix_valid_q <= 1'b0;
      pix_data_q  <= '0;
      pix_sol_q   <= 1'b0;
      pix_eol_q   <= 1'b0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      trig_cnt_q  <= trig_cnt_d;
      lines_cfg_q <= lines_cfg_d;
      flush_cnt_q <= flush_cnt_d;
      line_cnt_q  <= line_cnt_d;
      skip_cnt_q  <= skip_cnt_d;
      pix_idx_q   <= pix_idx_d;
      dly_cnt_q   <= dly_cnt_d;
      dly_act_q   <= dly_act_d;
      to_cnt_q    <= to_cnt_d;
      pix_valid_q <= pix_valid_d;
      pix_data_q  <= pix_data_d;
      pix_sol_q   <= pix_sol_d;
      pix_eol_q   <= pix_eol_d;
      done_q      <= done_d;
      overrun_q   <= overrun_d;
      err_q       <= err_d;
    end
  end

  assign trig          = (state_q == ST_ARM) && (trig_cnt_q != TRIG_LAST);
  assign busy          = (state_q != ST_IDLE);
  assign done          = done_q;
  assign overrun       = overrun_q;
  assign err_timeout   = err_q;
  assign pix.pix_valid = pix_valid_q;
  assign pix.pix_data  = pix_data_q;
  assign pix.pix_sol   = pix_sol_q;
  assign pix.pix_eol   = pix_eol_q;
endmodule

// File: doc/ccd_acq_sequencer.md
Name: ccd_acq_sequencer

Overview:
Acquisition controller for the TCD1500C timing generator. It arms the generator with a TRIG pulse and tracks its SH/SP outputs to find line boundaries. It discards a programmable number of flush lines, then captures ADC samples on SP edges, drops the leading dummy pixels, and streams PIXELS effective samples per line with frame markers. It sits between the host register block and the timing generator, ADC and line-buffer writer.

Parameters:
PIXELS, 5340, effective pixels streamed per line
DUMMY_LEAD, 64, SP pulses after SH fall discarded before first effective pixel
ADC_W, 12, ADC sample width
SAMPLE_DLY, 6, CLK20M cycles from synced SP rise to ADC sample capture (0..15)
TIMEOUT, 2000000, CLK20M cycles without SH edge before error

Ports:
CLK20M  in  1  system clock, 20 MHz
RST  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; begin acquisition (ignored when busy)
abort  in  1  one-cycle pulse; stop acquisition, return to IDLE
cfg_lines  in  8  lines to capture; 0 = continuous until abort
cfg_flush  in  4  lines discarded before first captured line
trig  out  1  TRIG pulse to timing generator
ccd_sh  in  1  SH from timing generator (asynchronous domain)
ccd_sp  in  1  SP from timing generator
adc_data  in  ADC_W  ADC output, stable at capture point
pix_data  out  ADC_W  pixel sample
pix_valid  out  1  sample valid
pix_ready  in  1  downstream accepts
pix_sol  out  1  first pixel of line, qualified by pix_valid
pix_eol  out  1  last pixel of line, qualified by pix_valid
busy  out  1  high outside IDLE
done  out  1  one-cycle pulse when cfg_lines lines have completed
overrun  out  1  sticky; sample dropped because output register was full
err_timeout  out  1  sticky; SH edge missing for TIMEOUT cycles

Behaviour:
- Reset values: all outputs 0, FSM IDLE, counters 0. RST is asynchronous on every flop, including synchronizers.
- ccd_sh and ccd_sp: 2-flop synchronized, then edge detected; edges lag the pins by 3 cycles.
- Config latch: cfg_lines and cfg_flush are latched on accepted start; later changes have no effect.
- Sticky flags: overrun and err_timeout clear only on RST or on accepted start.
- IDLE: on start, latch config, clear flags, go ARM.
- ARM: trig is high for exactly 4 cycles. Then wait for SH rising edge, go WAIT_SH_FALL.
- WAIT_SH_FALL: on SH falling edge, go FLUSH if flush count remains, else SKIP.
- FLUSH: ignore SP. On SH rising edge, decrement flush count and go WAIT_SH_FALL.
- SKIP: count SP rising edges. After the DUMMY_LEAD-th edge, go CAPTURE. The first effective pixel is at SP edge DUMMY_LEAD+1.
- CAPTURE: on each SP rising edge, start a SAMPLE_DLY countdown. At expiry, register adc_data.
  - Tag the sample pix_sol if pixel index is 0, pix_eol if it is PIXELS-1.
  - After PIXELS samples, increment line count.
  - If line count equals cfg_lines and cfg_lines is not 0: pulse done and go IDLE.
  - Otherwise go WAIT_SH_FALL.
- Output register: one entry. A new sample while pix_valid && !pix_ready is dropped and sets overrun. pix_valid is held until the handshake; data and markers stay stable while pix_valid is high.
- SH rising edge during SKIP or CAPTURE: short line. Do not emit eol for the short line. Set overrun. Continue at WAIT_SH_FALL; the line is not counted.
- Timeout: a counter clears on every SH edge and runs in states ARM through CAPTURE. When it reaches TIMEOUT, set err_timeout and go IDLE. done is not pulsed.
- abort: takes priority over every transition and goes IDLE next cycle. A pending pix_valid still completes its handshake. done is not pulsed.
- start and abort in the same cycle: abort wins and start is ignored.
- Counter widths: pixel index 13 b, SP skip count 7 b, line count 8 b, timeout 21 b. No wrap in the allowed ranges.

Decomposition:
- Shared package (ccd_pkg): FSM state enum; constants for PIXELS, DUMMY_LEAD and the TRIG pulse width (4).
- One sub-module: ccd_sync_edge. It holds the 2-flop synchronizer and rise/fall pulse generator, used for SH and SP.

Test Plan:
- Basic capture: cfg_flush=0, cfg_lines=1, ideal SH/SP model, ADC ramp, pix_ready=1 -> exactly 5340 valid samples starting at dummy+1 ramp value; sol on first, eol on last; one done pulse; busy falls.
- Flush: cfg_flush=2, cfg_lines=2 -> first two SH periods emit nothing; two complete lines emitted; done after second eol.
- Backpressure: pix_ready low for 2 samples -> overrun=1; the held sample stays stable until accepted; the next line still streams.
- Short line: SH rise injected at pixel 100 of CAPTURE -> no eol; overrun=1; next line is full 5340 and counted.
- Abort and continuous mode: cfg_lines=0, abort mid-line -> IDLE within 1 cycle; no done; start with abort same cycle -> stays IDLE.
- Timeout: SH stuck low after start -> err_timeout=1 after 2000000 cycles; FSM returns to IDLE; flag clears on next start.
